seven_seg_scan_driver: RTL and testbench

// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits. Holds a hex value
// (one nibble per digit), scans the digits at a programmable refresh rate and drives shared

---
 rtl/seven_seg_scan_driver_pkg.sv | 19 +
 rtl/seven_seg_scan_driver_if.sv | 29 ++
 rtl/seven_seg_scan_driver_encoder.sv | 14 +
 rtl/seven_seg_scan_driver.sv | 144 ++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared seven-segment definitions: segment width, blank pattern and the
// active-low {a..g} glyph table for hex digits 0..F.
package seg_pkg;

  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic logic [SEG_W-1:0] hexToSeg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Load channel of the display driver: a value/dp/lz_en word offered with a
// valid/ready handshake by the result path (master) to the driver (slave).
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_value;
  logic [NUM_DIGITS-1:0]   load_dp;
  logic                    lz_en;

  modport master (
    output load_valid,
    output load_value,
    output load_dp,
    output lz_en,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_value,
    input  load_dp,
    input  lz_en,
    output load_ready
  );

endinterface

// File: rtl/seven_seg_scan_driver_encoder.sv
// Combinational hex-nibble to active-low segment encoder with a blank override.
module seven_seg_hex_encoder
  import seg_pkg::*;
(
  input  logic [3:0]       nibble_i,
  input  logic             blank_i,
  output logic [SEG_W-1:0] seg_n_o
);

  always_comb begin
    seg_n_o = blank_i ? SEG_BLANK : hexToSeg(nibble_i);
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with a double-buffered
// display value, anti-ghost dead time and leading-zero blanking.
module seven_seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  seven_seg_scan_driver_if.slave  load_if,
  output logic [SEG_W-1:0]        seg_n_o,
  output logic                    dp_n_o,
  output logic [NUM_DIGITS-1:0]   an_n_o,
  output logic                    frame_done_o
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         prescaler_q, prescaler_d;
  logic [IW-1:0]         digitIdx_q, digitIdx_d;
  logic [VW-1:0]         pendValue_q, pendValue_d;
  logic [NUM_DIGITS-1:0] pendDp_q, pendDp_d;
  logic                  pendLz_q, pendLz_d;
  logic                  pending_q, pending_d;
  logic [VW-1:0]         dispValue_q, dispValue_d;
  logic [NUM_DIGITS-1:0] dispDp_q, dispDp_d;
  logic                  dispLz_q, dispLz_d;
  logic [SEG_W-1:0]      segN_q, segN_d;
  logic                  dpN_q, dpN_d;
  logic [NUM_DIGITS-1:0] anN_q, anN_d;
  logic                  frameDone_q, frameDone_d;

  logic                  slotWrap, frameEnd, accept, blankPhase, encBlank, lzKeep;
  logic [NUM_DIGITS-1:0] lzBlank;
  logic [3:0]            curNibble;
  logic [SEG_W-1:0]      encSeg;

  assign load_if.load_ready = ~pending_q;

  // A digit stays blanked until scanning downward meets a nonzero nibble or a lit dp.
  always_comb begin
    lzBlank = '0;
    lzKeep  = ~dispLz_q;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (dispValue_q[4*i +: 4] != 4'h0 || dispDp_q[i]) begin
        lzKeep = 1'b1;
      end
      lzBlank[i] = ~lzKeep;
    end
  end

  always_comb begin
    slotWrap    = (prescaler_q == PRESC_LAST);
    frameEnd    = slotWrap && (digitIdx_q == IDX_LAST);
    accept      = load_if.load_valid && ~pending_q;
    blankPhase  = (prescaler_q < BLANK_END);
    curNibble   = dispValue_q[4*digitIdx_q +: 4];
    encBlank    = blankPhase | lzBlank[digitIdx_q];

    prescaler_d = slotWrap ? '0 : prescaler_q + PW'(1);
    digitIdx_d  = digitIdx_q;
    if (slotWrap) begin
      digitIdx_d = (digitIdx_q == IDX_LAST) ? '0 : digitIdx_q + IW'(1);
    end

    pendValue_d = pendValue_q;
    pendDp_d    = pendDp_q;
    pendLz_d    = pendLz_q;
    pending_d   = pending_q;
    dispValue_d = dispValue_q;
    dispDp_d    = dispDp_q;
    dispLz_d    = dispLz_q;

    // Commit and accept are mutually exclusive because accept requires an empty buffer.
    if (frameEnd && pending_q) begin
      dispValue_d = pendValue_q;
      dispDp_d    = pendDp_q;
      dispLz_d    = pendLz_q;
      pending_d   = 1'b0;
    end
    if (accept) begin
      pendValue_d = load_if.load_value;
      pendDp_d    = load_if.load_dp;
      pendLz_d    = load_if.lz_en;
      pending_d   = 1'b1;
    end

    segN_d      = encSeg;
    anN_d       = blankPhase ? '1 : ~(NUM_DIGITS'(1) << digitIdx_q);
    dpN_d       = blankPhase | ~dispDp_q[digitIdx_q];
    frameDone_d = frameEnd;
  end

  seven_seg_hex_encoder u_encoder (
    .nibble_i (curNibble),
    .blank_i  (encBlank),
    .seg_n_o  (encSeg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q <= '0;
      digitIdx_q  <= '0;
      pendValue_q <= '0;
      pendDp_q    <= '0;
      pendLz_q    <= 1'b0;
      pending_q   <= 1'b0;
      dispValue_q <= '0;
      dispDp_q    <= '0;
      dispLz_q    <= 1'b0;
      segN_q      <= SEG_BLANK;
      dpN_q       <= 1'b1;
      anN_q       <= '1;
      frameDone_q <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      digitIdx_q  <= digitIdx_d;
      pendValue_q <= pendValue_d;
      pendDp_q    <= pendDp_d;
      pendLz_q    <= pendLz_d;
      pending_q   <= pending_d;
      dispValue_q <= dispValue_d;
      dispDp_q    <= dispDp_d;
      dispLz_q    <= dispLz_d;
      segN_q      <= segN_d;
      dpN_q       <= dpN_d;
      anN_q       <= anN_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign seg_n_o      = segN_q;
  assign dp_n_o       = dpN_q;
  assign an_n_o       = anN_q;
  assign frame_done_o = frameDone_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver: table-driven display frames
// compared through an expected-output queue, plus reset and parameter corners.
module tb_seven_seg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BC = 1;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;

  always #5 clk = ~clk;

  seven_seg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();
  seven_seg_scan_driver_if #(.NUM_DIGITS(3))  bus2 ();

  logic [6:0] segN, segN2;
  logic       dpN, dpN2, fd, fd2;
  logic [3:0] anN;
  logic [2:0] anN2;

  seven_seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_if      (bus.slave),
    .seg_n_o      (segN),
    .dp_n_o       (dpN),
    .an_n_o       (anN),
    .frame_done_o (fd)
  );

  seven_seg_scan_driver #(.NUM_DIGITS(3), .REFRESH_DIV(5), .BLANK_CYCLES(0)) dut2 (
    .clk          (clk),
    .rst          (rst2),
    .load_if      (bus2.slave),
    .seg_n_o      (segN2),
    .dp_n_o       (dpN2),
    .an_n_o       (anN2),
    .frame_done_o (fd2)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } obs_t;

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0][6:0] seg;
    logic [3:0]      dpn;
  } vec_t;

  vec_t vecs [9];
  obs_t expQ [$];
  int   checks = 0;
  int   errors = 0;

  task automatic setVec(input int k, input logic [15:0] v, input logic [3:0] dp, input logic lz,
                        input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                        input logic [6:0] s0, input logic [3:0] dpn);
    vecs[k].value = v;
    vecs[k].dp    = dp;
    vecs[k].lz    = lz;
    vecs[k].seg   = {s3, s2, s1, s0};
    vecs[k].dpn   = dpn;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] v, input logic [3:0] dp,
                               input logic lz);
    bus.load_valid = valid;
    bus.load_value = v;
    bus.load_dp    = dp;
    bus.lz_en      = lz;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected output for sample i (1..16) of a frame displaying table entry e.
  function automatic obs_t expFrame(input int e, input int i);
    obs_t       o;
    int         j, d, p;
    logic [3:0] onehot;
    j = i - 1;
    d = j / RD;
    p = j % RD;
    onehot = 4'b0001 << d;
    if (p < BC) begin
      o.an  = 4'hF;
      o.seg = 7'h7F;
      o.dp  = 1'b1;
    end else begin
      o.an  = ~onehot;
      o.seg = vecs[e].seg[d];
      o.dp  = vecs[e].dpn[d];
    end
    o.fd = (i == 16);
    return o;
  endfunction

  task automatic compareObs(input string tag, input logic [3:0] an, input logic [6:0] seg,
                            input logic dp, input logic f);
    obs_t exp;
    if (expQ.size() == 0) begin
      checkOutput({tag, "/queue"}, 0, 1);
      return;
    end
    exp = expQ.pop_front();
    checkOutput({tag, "/an"},  an,  exp.an);
    checkOutput({tag, "/seg"}, seg, exp.seg);
    checkOutput({tag, "/dp"},  dp,  exp.dp);
    checkOutput({tag, "/fd"},  f,   exp.fd);
  endtask

  // One full frame; optionally offers entry nextE at sample loadAt and keeps valid
  // asserted with junk while the buffer is full.
  task automatic runFrame(input int e, input int loadAt, input int nextE);
    for (int i = 1; i <= 16; i++) begin
      if (loadAt >= 0) begin
        if (i == loadAt)
          applyStimulus(1'b1, vecs[nextE].value, vecs[nextE].dp, vecs[nextE].lz);
        else if (i > loadAt && i < 16)
          applyStimulus(1'b1, 16'hFFFF, 4'hF, 1'b0);
        else if (i == 16)
          applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0);
      end
      expQ.push_back(expFrame(e, i));
      step();
      compareObs($sformatf("v%0d.c%0d", e, i), anN, segN, dpN, fd);
      if (loadAt >= 0 && i == loadAt)
        checkOutput($sformatf("v%0d.readyDrop", e), bus.load_ready, 1'b0);
    end
    if (loadAt >= 0)
      checkOutput($sformatf("v%0d.readyBack", e), bus.load_ready, 1'b1);
  endtask

  task automatic loadAndSync(input int e);
    int n;
    applyStimulus(1'b1, vecs[e].value, vecs[e].dp, vecs[e].lz);
    step();
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0);
    checkOutput($sformatf("v%0d.acceptReady", e), bus.load_ready, 1'b0);
    n = 0;
    while (bus.load_ready !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    checkOutput($sformatf("v%0d.commitSeen", e), bus.load_ready, 1'b1);
    checkOutput($sformatf("v%0d.commitFrameDone", e), fd, 1'b1);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "/seg"},   segN, 7'h7F);
    checkOutput({tag, "/an"},    anN, 4'hF);
    checkOutput({tag, "/dp"},    dpN, 1'b1);
    checkOutput({tag, "/fd"},    fd, 1'b0);
    checkOutput({tag, "/ready"}, bus.load_ready, 1'b1);
  endtask

  initial begin
    obs_t       o;
    int         d;
    logic [2:0] onehot3;

    setVec(0, 16'h0000, 4'b0000, 1'b0, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001, 4'b1111);
    setVec(1, 16'h1234, 4'b0000, 1'b0, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 4'b1111);
    setVec(2, 16'hABCD, 4'b0000, 1'b0, 7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 4'b1111);
    setVec(3, 16'h0050, 4'b0000, 1'b1, 7'h7F,      7'h7F,      7'b0100100, 7'b0000001, 4'b1111);
    setVec(4, 16'h0000, 4'b0000, 1'b1, 7'h7F,      7'h7F,      7'h7F,      7'b0000001, 4'b1111);
    setVec(5, 16'h0050, 4'b0100, 1'b1, 7'h7F,      7'b0000001, 7'b0100100, 7'b0000001, 4'b1011);
    setVec(6, 16'h0050, 4'b0000, 1'b0, 7'b0000001, 7'b0000001, 7'b0100100, 7'b0000001, 4'b1111);
    setVec(7, 16'h89EF, 4'b1001, 1'b1, 7'b0000000, 7'b0000100, 7'b0110000, 7'b0111000, 4'b0110);
    setVec(8, 16'h0700, 4'b0001, 1'b1, 7'h7F,      7'b0001111, 7'b0000001, 7'b0000001, 4'b1110);

    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0);
    bus2.load_valid = 1'b0;
    bus2.load_value = '0;
    bus2.load_dp    = '0;
    bus2.lz_en      = 1'b0;

    $display("[TB] reset");
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      checkReset($sformatf("reset%0d", k));
    end
    rst = 1'b0;
    runFrame(0, -1, 0);

    $display("[TB] scan 1234");
    loadAndSync(1);
    runFrame(1, -1, 0);
    runFrame(1, -1, 0);

    $display("[TB] no tearing");
    runFrame(1, 6, 2);
    runFrame(2, -1, 0);

    $display("[TB] leading zeros and dp");
    for (int e = 3; e <= 8; e++) begin
      loadAndSync(e);
      runFrame(e, -1, 0);
    end

    $display("[TB] reset mid-frame with load pending");
    applyStimulus(1'b1, vecs[1].value, vecs[1].dp, vecs[1].lz);
    step();
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0);
    checkOutput("midReset.pendingTaken", bus.load_ready, 1'b0);
    for (int k = 0; k < 8; k++) step();
    rst = 1'b1;
    step();
    checkReset("midReset");
    rst = 1'b0;
    runFrame(0, -1, 0);
    runFrame(0, -1, 0);
    checkOutput("midReset.readyAfter", bus.load_ready, 1'b1);

    $display("[TB] NUM_DIGITS=3 REFRESH_DIV=5 BLANK_CYCLES=0");
    rst2 = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      d       = ((i - 1) / 5) % 3;
      onehot3 = 3'b001 << d;
      o.an    = {1'b1, ~onehot3};
      o.seg   = 7'b0000001;
      o.dp    = 1'b1;
      o.fd    = (i % 15 == 0);
      expQ.push_back(o);
      step();
      compareObs($sformatf("sweep.c%0d", i), {1'b1, anN2}, segN2, dpN2, fd2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
